// File: rtl/rco_mon_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rco_mon_if : strobe input, clear and status bundle of rco_monitor  |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
interface rco_mon_if #(
  parameter int CNT_W = 8
);
  logic             rco_in;
  logic             clear;
  logic [CNT_W-1:0] tick_count;
  logic             locked;
  logic             err_early;
  logic             err_late;
  logic [1:0]       state;

  modport master (
    output rco_in, clear,
    input  tick_count, locked, err_early, err_late, state
  );

  modport slave (
    input  rco_in, clear,
    output tick_count, locked, err_early, err_late, state
  );
endinterface
`default_nettype wire

// File: rtl/rco_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rco_monitor : checks carry-strobe spacing, locks after good runs.  |
// | Options     : RCO_MON_STICKY_ERR_EN holds error flags until clear. |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module rco_monitor #(
  parameter int PERIOD     = 4,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 8
) (
  input  wire       clk,
  input  wire       reset,
  rco_mon_if.slave  bus
);
  localparam int GAP_W = $clog2(PERIOD + 1);

  localparam logic [1:0] c_idle    = 2'b00;
  localparam logic [1:0] c_acquire = 2'b01;
  localparam logic [1:0] c_locked  = 2'b10;

  localparam logic [GAP_W-1:0] c_gap_max  = GAP_W'(PERIOD);
  localparam logic [GAP_W-1:0] c_gap_good = GAP_W'(PERIOD - 1);
  localparam logic [3:0]       c_lock_cnt = 4'(LOCK_COUNT);

  logic             r_rco_q;
  logic [GAP_W-1:0] r_gap;
  logic [3:0]       r_good_cnt;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_locked;
  logic             r_err_early;
  logic             r_err_late;

  logic             w_event;
  logic             w_early;
  logic             w_late;
  logic [1:0]       w_state_nxt;
  logic [3:0]       w_good_nxt;
  logic [GAP_W-1:0] w_gap_nxt;

  assign w_event = bus.rco_in & ~r_rco_q;

  always_comb begin
    w_early     = 1'b0;
    w_late      = 1'b0;
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_gap_nxt   = w_event ? '0 : ((r_gap == c_gap_max) ? r_gap : r_gap + 1'b1);
    case (r_state)
      c_idle: begin
        if (w_event) begin
          w_state_nxt = c_acquire;
          w_good_nxt  = 4'd0;
        end
      end
      c_acquire, c_locked: begin
        // A saturated gap means the expected strobe was missed, even if one shows up now.
        if (r_gap == c_gap_max) begin
          w_late      = 1'b1;
          w_state_nxt = c_idle;
          w_good_nxt  = 4'd0;
        end else if (w_event && (r_gap < c_gap_good)) begin
          w_early     = 1'b1;
          w_state_nxt = c_idle;
          w_good_nxt  = 4'd0;
        end else if (w_event && (r_state == c_acquire)) begin
          if (r_good_cnt + 4'd1 == c_lock_cnt) begin
            w_state_nxt = c_locked;
            w_good_nxt  = 4'd0;
          end else begin
            w_good_nxt  = r_good_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = c_idle;
        w_good_nxt  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rco_q     <= 1'b0;
      r_gap       <= '0;
      r_good_cnt  <= 4'd0;
      r_state     <= c_idle;
      r_count     <= '0;
      r_locked    <= 1'b0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
    end else if (bus.clear) begin
      // Edge history keeps tracking so a strobe held across clear is not recounted.
      r_rco_q     <= bus.rco_in;
      r_gap       <= '0;
      r_good_cnt  <= 4'd0;
      r_state     <= c_idle;
      r_count     <= '0;
      r_locked    <= 1'b0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      r_rco_q    <= bus.rco_in;
      r_gap      <= w_gap_nxt;
      r_good_cnt <= w_good_nxt;
      r_state    <= w_state_nxt;
      r_locked   <= (w_state_nxt == c_locked);
      if (w_event) begin
        r_count <= r_count + 1'b1;
      end
`ifdef RCO_MON_STICKY_ERR_EN
      r_err_early <= r_err_early | w_early;
      r_err_late  <= r_err_late | w_late;
`else
      r_err_early <= w_early;
      r_err_late  <= w_late;
`endif
    end
  end

  assign bus.tick_count = r_count;
  assign bus.locked     = r_locked;
  assign bus.err_early  = r_err_early;
  assign bus.err_late   = r_err_late;
  assign bus.state      = r_state;
endmodule
`default_nettype wire

// File: tb/tb_rco_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rco_monitor : directed self-checking bench for rco_monitor      |
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module tb_rco_monitor;
`ifdef RCO_MON_STICKY_ERR_EN
  localparam logic c_sticky = 1'b1;
`else
  localparam logic c_sticky = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  rco_mon_if #(.CNT_W(8)) bus ();

  rco_monitor #(
    .PERIOD     (4),
    .LOCK_COUNT (3),
    .CNT_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    bus.rco_in = 1'b1;
    tick(1);
    bus.rco_in = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [7:0] cnt, input logic [1:0] st,
                           input logic lk, input logic ee, input logic el);
    check({tag, ".count"},  32'(bus.tick_count), 32'(cnt));
    check({tag, ".state"},  32'(bus.state),      32'(st));
    check({tag, ".locked"}, 32'(bus.locked),     32'(lk));
    check({tag, ".early"},  32'(bus.err_early),  32'(ee));
    check({tag, ".late"},   32'(bus.err_late),   32'(el));
  endtask

  // Four strobes exactly 4 clocks apart, starting from IDLE.
  task automatic lock_seq();
    pulse();
    repeat (3) begin
      tick(3);
      pulse();
    end
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    reset      = 1'b0;
    bus.rco_in = 1'b0;
    bus.clear  = 1'b0;
    #100;
    check_all("reset", 8'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1);

    pulse();
    check_all("acq1", 8'd1, 2'b01, 1'b0, 1'b0, 1'b0);
    tick(3); pulse();
    check_all("acq2", 8'd2, 2'b01, 1'b0, 1'b0, 1'b0);
    tick(3); pulse();
    check_all("acq3", 8'd3, 2'b01, 1'b0, 1'b0, 1'b0);
    tick(3); pulse();
    check_all("lock", 8'd4, 2'b10, 1'b1, 1'b0, 1'b0);

    tick(1); pulse();
    check_all("early", 8'd5, 2'b00, 1'b0, 1'b1, 1'b0);
    tick(1);
    check("early_hold1", 32'(bus.err_early), 32'(c_sticky));
    tick(9);
    check("early_hold10", 32'(bus.err_early), 32'(c_sticky));
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    check_all("clear_err", 8'd0, 2'b00, 1'b0, 1'b0, 1'b0);

    lock_seq();
    check_all("relock", 8'd4, 2'b10, 1'b1, 1'b0, 1'b0);
    tick(4);
    check_all("late_pre", 8'd4, 2'b10, 1'b1, 1'b0, 1'b0);
    tick(1);
    check_all("late", 8'd4, 2'b00, 1'b0, 1'b0, 1'b1);
    tick(1);
    check("late_hold", 32'(bus.err_late), 32'(c_sticky));

    bus.rco_in = 1'b1;
    tick(5);
    check("held_count", 32'(bus.tick_count), 32'd5);
    check("held_state", 32'(bus.state), 32'd1);
    bus.rco_in = 1'b0;
    tick(1);
    check("held_late", 32'(bus.err_late), 32'd1);
    check("held_late_st", 32'(bus.state), 32'd0);

    pulse();
    tick(3); pulse();
    check("pre_clear_cnt", 32'(bus.tick_count), 32'd7);
    check("pre_clear_st", 32'(bus.state), 32'd1);
    bus.clear  = 1'b1;
    bus.rco_in = 1'b1;
    tick(1);
    bus.clear = 1'b0;
    check_all("clear_evt", 8'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(1);
    check("clear_held", 32'(bus.tick_count), 32'd0);
    bus.rco_in = 1'b0;
    tick(1);

    lock_seq();
    check_all("lock3", 8'd4, 2'b10, 1'b1, 1'b0, 1'b0);
    #5;
    reset = 1'b0;
    #1;
    check_all("async_rst", 8'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    tick(1);
    reset = 1'b1;
    tick(1);
    pulse();
    check_all("post_rst", 8'd1, 2'b01, 1'b0, 1'b0, 1'b0);

    // 256 closely spaced strobes alternate ACQUIRE/IDLE and wrap the counter.
    for (int i = 0; i < 256; i++) begin
      tick(1);
      pulse();
    end
    check("wrap_count", 32'(bus.tick_count), 32'd1);
    check("wrap_state", 32'(bus.state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
